// File: rtl/pipe_add_sub_w.sv
// Pipelined WIDTH-bit add/subtract that adds one CHUNK-bit slice per stage and registers the carry between stages.
// Optional out_zero flag when PIPE_ADD_SUB_ZERO_DET_EN is defined.
module pipe_add_sub_w #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
  ,
  output logic             out_zero
`endif
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic advance;

  // One stall signal freezes every stage, so beats and bubbles keep their spacing.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : st
    localparam int LO = gi * CHUNK;
    localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
    localparam int SW = HI - LO + 1;

    logic             valid_reg;
    logic             carry_reg;
    logic [HI:0]      sum_reg;
    logic             src_valid;
    logic             src_carry;
    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    logic [HI:0]      sum_next;
    logic [SW-1:0]    slice_sum;
    logic             slice_cout;
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
    logic             zero_reg;
    logic             src_zero;
`endif

    if (gi == 0) begin : g_in
      // Subtraction is A + ~B + !borrow; the inversion happens once, here.
      assign src_valid = in_valid;
      assign a_src     = in_a;
      assign b_src     = in_sub ? ~in_b : in_b;
      assign src_carry = in_sub ? ~in_cin : in_cin;
      assign sum_next  = slice_sum;
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
      assign src_zero  = 1'b1;
`endif
    end else begin : g_chain
      assign src_valid = st[gi-1].valid_reg;
      assign a_src     = st[gi-1].g_skew.a_reg;
      assign b_src     = st[gi-1].g_skew.b_reg;
      assign src_carry = st[gi-1].carry_reg;
      assign sum_next  = {slice_sum, st[gi-1].sum_reg};
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
      assign src_zero  = st[gi-1].zero_reg;
`endif
    end

    assign {slice_cout, slice_sum} = {1'b0, a_src[HI:LO]} + {1'b0, b_src[HI:LO]}
                                   + {{SW{1'b0}}, src_carry};

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= src_valid;
        carry_reg <= slice_cout;
        sum_reg   <= sum_next;
      end
    end

`ifdef PIPE_ADD_SUB_ZERO_DET_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        zero_reg <= 1'b0;
      end else if (advance) begin
        zero_reg <= src_zero && (slice_sum == '0);
      end
    end
`endif

    if (gi < STAGES - 1) begin : g_skew
      // Only the operand slices still to be added travel onward.
      logic [WIDTH-1:HI+1] a_reg;
      logic [WIDTH-1:HI+1] b_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (advance) begin
          a_reg <= a_src[WIDTH-1:HI+1];
          b_reg <= b_src[WIDTH-1:HI+1];
        end
      end
    end else begin : g_last
      // Carry-in XOR carry-out of the MSB, expressed via operand and result signs.
      logic ovf_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= (a_src[WIDTH-1] == b_src[WIDTH-1]) && (slice_sum[SW-1] != a_src[WIDTH-1]);
        end
      end
    end
  end

  assign out_valid = st[STAGES-1].valid_reg;
  assign out_sum   = st[STAGES-1].sum_reg;
  assign out_cout  = st[STAGES-1].carry_reg;
  assign out_ovf   = st[STAGES-1].g_last.ovf_reg;
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
  assign out_zero  = st[STAGES-1].zero_reg;
`endif

endmodule

// File: tb/tb_pipe_add_sub_w.sv
// Directed and randomised checks of pipe_add_sub_w: default 128/24 build plus 8/24 and 65/16 instances.
module tb_pipe_add_sub_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rnd_rdy;
  logic one_b;

  logic         v0, r0, sub0, cin0, ov0, ordy0, cout0, ovf0;
  logic [127:0] a0, b0, sum0;

  logic         vs, subs, cins;
  logic         r1, ov1, cout1, ovf1;
  logic [7:0]   a1, b1, sum1;
  logic         r2, ov2, cout2, ovf2;
  logic [64:0]  a2, b2, sum2;
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
  logic         oz0, oz1, oz2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [129:0] q0[$], q1[$], q2[$];
  logic [129:0] e0, e1, e2, hold_val;
  logic         hold_pend;

  pipe_add_sub_w #(.WIDTH(128), .CHUNK(24)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
    .in_sub(sub0), .in_cin(cin0), .out_valid(ov0), .out_ready(ordy0),
    .out_sum(sum0), .out_cout(cout0), .out_ovf(ovf0)
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
    , .out_zero(oz0)
`endif
  );

  pipe_add_sub_w #(.WIDTH(8), .CHUNK(24)) u1 (
    .clk(clk), .rst(rst), .in_valid(vs), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_sub(subs), .in_cin(cins), .out_valid(ov1), .out_ready(one_b),
    .out_sum(sum1), .out_cout(cout1), .out_ovf(ovf1)
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
    , .out_zero(oz1)
`endif
  );

  pipe_add_sub_w #(.WIDTH(65), .CHUNK(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(vs), .in_ready(r2), .in_a(a2), .in_b(b2),
    .in_sub(subs), .in_cin(cins), .out_valid(ov2), .out_ready(one_b),
    .out_sum(sum2), .out_cout(cout2), .out_ovf(ovf2)
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
    , .out_zero(oz2)
`endif
  );

  task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [129:0] mk(input logic ovf, input logic cout, input logic [127:0] sum);
    return {ovf, cout, sum};
  endfunction

  // Reference: plain wide arithmetic, ovf from the carry into and out of bit w-1.
  function automatic logic [129:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                         input logic sub, input logic cin);
    logic [129:0] mask, lmask, bb, full, low;
    logic c;
    mask  = (130'd1 << w) - 130'd1;
    lmask = (130'd1 << (w - 1)) - 130'd1;
    bb    = (sub ? ~{2'b00, b} : {2'b00, b}) & mask;
    c     = sub ? !cin : cin;
    full  = {2'b00, a} + bb + {129'd0, c};
    low   = ({2'b00, a} & lmask) + (bb & lmask) + {129'd0, c};
    return {low[w-1] ^ full[w], full[w], full[127:0] & mask[127:0]};
  endfunction

  // Output-side monitors: results in order, stall stability, in_ready rule.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      check("in_ready_rule", 131'(r0), 131'(!(ov0 && !ordy0)));
      if (hold_pend) check("stall_hold", 131'({ov0, ovf0, cout0, sum0}), 131'({1'b1, hold_val}));
      hold_pend = ov0 && !ordy0;
      hold_val  = {ovf0, cout0, sum0};
      if (ov0 && ordy0) begin
        if (q0.size() == 0) check("extra_beat0", 131'(ov0), 131'(0));
        else begin
          e0 = q0.pop_front();
          check("result0", 131'({ovf0, cout0, sum0}), 131'(e0));
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
          check("zero0", 131'(oz0), 131'(e0[127:0] == 128'd0));
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1) begin
      if (q1.size() == 0) check("extra_beat1", 131'(ov1), 131'(0));
      else begin
        e1 = q1.pop_front();
        check("result_w8", 131'({ovf1, cout1, 120'd0, sum1}), 131'(e1));
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
        check("zero_w8", 131'(oz1), 131'(e1[127:0] == 128'd0));
`endif
      end
    end
    if (!rst && ov2) begin
      if (q2.size() == 0) check("extra_beat2", 131'(ov2), 131'(0));
      else begin
        e2 = q2.pop_front();
        check("result_w65", 131'({ovf2, cout2, 63'd0, sum2}), 131'(e2));
`ifdef PIPE_ADD_SUB_ZERO_DET_EN
        check("zero_w65", 131'(oz2), 131'(e2[127:0] == 128'd0));
`endif
      end
    end
  end

  initial begin
    ordy0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ordy0 = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send0(input logic [127:0] a, input logic [127:0] b, input logic sub,
                       input logic cin, input logic [129:0] exp);
    int g = 0;
    a0 = a; b0 = b; sub0 = sub; cin0 = cin; v0 = 1'b1;
    @(negedge clk);
    while (!r0 && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!r0) check("send_timeout0", 131'(r0), 131'(1));
    else q0.push_back(exp);
    @(posedge clk);
    #1;
    v0 = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] x1, input logic [7:0] y1, input logic [64:0] x2,
                        input logic [64:0] y2, input logic sub, input logic cin,
                        input logic [129:0] exp1, input logic [129:0] exp2);
    int g = 0;
    a1 = x1; b1 = y1; a2 = x2; b2 = y2; subs = sub; cins = cin; vs = 1'b1;
    @(negedge clk);
    while (!(r1 && r2) && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (!(r1 && r2)) check("send_timeout_s", 131'(r1 && r2), 131'(1));
    else begin
      q1.push_back(exp1);
      q2.push_back(exp2);
    end
    @(posedge clk);
    #1;
    vs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] ra, rb;
    logic [7:0]   s1a, s1b;
    logic [64:0]  s2a, s2b;
    logic         rs, rc;

    rst = 1'b1; rnd_rdy = 1'b0; one_b = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0; cin0 = 1'b0;
    vs = 1'b0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; subs = 1'b0; cins = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 131'(ov0), 131'(0));
    check("rst_outputs", 131'({ovf0, cout0, sum0}), 131'(0));
    check("rst_in_ready", 131'(r0), 131'(1));
    check("rst_valid_small", 131'({ov1, ov2}), 131'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-width carry wrap and six-stage latency.
    send0({128{1'b1}}, 128'd1, 1'b0, 1'b0, mk(1'b0, 1'b1, 128'd0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("latency_early", 131'(ov0), 131'(0));
    @(posedge clk);
    @(negedge clk);
    check("latency_on", 131'(ov0), 131'(1));
    @(posedge clk);
    #1;

    send0({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, mk(1'b1, 1'b0, {1'b1, 127'd0}));
    send0(128'd5, 128'd7, 1'b1, 1'b0, mk(1'b0, 1'b0, {{127{1'b1}}, 1'b0}));
    send0(128'd10, 128'd3, 1'b1, 1'b1, mk(1'b0, 1'b1, 128'd6));
    send0({64'd0, {64{1'b1}}}, 128'd0, 1'b0, 1'b1, mk(1'b0, 1'b0, {63'd0, 1'b1, 64'd0}));
    send0(128'd0, 128'd0, 1'b1, 1'b0, mk(1'b0, 1'b1, 128'd0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_directed", 131'(q0.size()), 131'(0));

    // Back-to-back random beats under random back-pressure.
    @(posedge clk);
    #1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send0(ra, rb, rs, rc, model(128, ra, rb, rs, rc));
    end
    rnd_rdy = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("drain_stream", 131'(q0.size()), 131'(0));

    // Reset with three beats in flight: none of them may surface.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      send0(ra, rb, 1'b0, 1'b0, model(128, ra, rb, 1'b0, 1'b0));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    check("midrst_out_valid", 131'(ov0), 131'(0));
    check("midrst_outputs", 131'({ovf0, cout0, sum0}), 131'(0));
    check("midrst_in_ready", 131'(r0), 131'(1));
    @(posedge clk);
    #1;
    send0(128'd1, 128'd2, 1'b0, 1'b0, mk(1'b0, 1'b0, 128'd3));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_after_rst", 131'(q0.size()), 131'(0));

    // Narrow instances: single-stage 8-bit and five-stage 65-bit with a 1-bit top slice.
    @(posedge clk);
    #1;
    send_s(8'hFF, 8'h01, {65{1'b1}}, 65'd1, 1'b0, 1'b0,
           mk(1'b0, 1'b1, 128'd0), mk(1'b0, 1'b1, 128'd0));
    @(negedge clk);
    check("latency_w8", 131'(ov1), 131'(1));
    check("latency_w65_early", 131'(ov2), 131'(0));
    @(posedge clk);
    #1;
    send_s(8'h7F, 8'h01, {1'b0, {64{1'b1}}}, 65'd1, 1'b0, 1'b0,
           mk(1'b1, 1'b0, 128'h80), mk(1'b1, 1'b0, {63'd0, 1'b1, 64'd0}));
    send_s(8'd5, 8'd7, 65'd5, 65'd7, 1'b1, 1'b0,
           mk(1'b0, 1'b0, 128'hFE), mk(1'b0, 1'b0, {63'd0, {64{1'b1}}, 1'b0}));
    for (int i = 0; i < 30; i++) begin
      s1a = 8'($urandom);
      s1b = 8'($urandom);
      s2a = {1'($urandom), $urandom, $urandom};
      s2b = {1'($urandom), $urandom, $urandom};
      rs  = 1'($urandom_range(0, 1));
      rc  = 1'($urandom_range(0, 1));
      send_s(s1a, s1b, s2a, s2b, rs, rc,
             model(8, {120'd0, s1a}, {120'd0, s1b}, rs, rc),
             model(65, {63'd0, s2a}, {63'd0, s2b}, rs, rc));
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_w8", 131'(q1.size()), 131'(0));
    check("drain_w65", 131'(q2.size()), 131'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
